// File: rtl/card_shoe.sv
// card_shoe: NUM_DECKS x 52 card store, filled in order after reset and shuffled
// in place by an LFSR-driven Fisher-Yates loop; cards stream out one per cycle.
module card_shoe #(
  parameter int NUM_DECKS      = 1,
  parameter int CUT_CARD       = 0,
  parameter bit AUTO_RESHUFFLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  input  logic        shuffle_req,
  input  logic        card_ready,
  output logic        card_valid,
  output logic [3:0]  card_rank,
  output logic [1:0]  card_suit,
  output logic [2:0]  card_deck,
  output logic [9:0]  cards_left,
  output logic        busy,
  output logic        cut_reached,
  output logic        shuffle_done,
  output logic [2:0]  state_dbg
);

  localparam int N     = 52 * NUM_DECKS;
  localparam int IDX_W = $clog2(N);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);
  localparam logic [9:0]       N_CARDS   = 10'(N);
  localparam logic [9:0]       CUT_LEFT  = 10'(N - CUT_CARD);
  localparam logic [15:0]      SEED_SUB  = 16'hACE1;
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_FILL, ST_SHUF_RD, ST_SHUF_SW, ST_LOAD, ST_IDLE
  } state_t;

  // Card word layout: {deck[2:0], suit[1:0], rank[3:0]}.
  typedef logic [8:0] card_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, j_q, j_d;
  logic [9:0]       left_q, left_d;
  logic [15:0]      lfsr_q, lfsr_d;
  card_t            swap_i_q, swap_i_d, swap_j_q, swap_j_d, card_q, card_d;
  logic             cut_q, cut_d, done_q, done_d;
  logic [3:0]       fill_rank_q, fill_rank_d;
  logic [1:0]       fill_suit_q, fill_suit_d;
  logic [2:0]       fill_deck_q, fill_deck_d;

  card_t            mem_q [N];
  logic             wr_a_en, wr_b_en;
  logic [IDX_W-1:0] wr_a_addr, wr_b_addr;
  card_t            wr_a_data, wr_b_data;

  logic             hs, start;
  logic [9:0]       left_after;
  logic [15:0]      lfsr_nx, seed_eff;
  logic [IDX_W-1:0] j_new;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // card_valid/card_ready: a card transfers on a rising edge where both are high;
  // card_valid never depends on card_ready, and card data and cards_left hold
  // while card_valid && !card_ready.
  assign card_valid   = (state_q == ST_IDLE) && (left_q != 10'd0);
  assign card_rank    = card_q[3:0];
  assign card_suit    = card_q[5:4];
  assign card_deck    = card_q[8:6];
  assign cards_left   = left_q;
  assign busy         = (state_q != ST_IDLE);
  assign cut_reached  = cut_q;
  assign shuffle_done = done_q;
  assign state_dbg    = state_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    j_d         = j_q;
    left_d      = left_q;
    lfsr_d      = lfsr_q;
    swap_i_d    = swap_i_q;
    swap_j_d    = swap_j_q;
    card_d      = card_q;
    cut_d       = cut_q;
    done_d      = (state_q == ST_LOAD);
    fill_rank_d = fill_rank_q;
    fill_suit_d = fill_suit_q;
    fill_deck_d = fill_deck_q;
    wr_a_en     = 1'b0;
    wr_b_en     = 1'b0;
    wr_a_addr   = idx_q;
    wr_b_addr   = j_q;
    wr_a_data   = swap_j_q;
    wr_b_data   = swap_i_q;

    hs         = card_valid && card_ready;
    left_after = hs ? (left_q - 10'd1) : left_q;
    start      = (state_q == ST_IDLE) &&
                 (shuffle_req || (AUTO_RESHUFFLE && (left_after == 10'd0)));
    seed_eff   = (seed == 16'h0000) ? SEED_SUB : seed;
    lfsr_nx    = lfsr_step(lfsr_q);
    // Scaling by (i+1) and keeping the top bits maps the LFSR word onto 0..i.
    j_new      = IDX_W'(({{IDX_W{1'b0}}, lfsr_nx} * {16'h0000, idx_q + ONE_IDX}) >> 16);

    case (state_q)
      ST_FILL: begin
        wr_a_en   = 1'b1;
        wr_a_data = {fill_deck_q, fill_suit_q, fill_rank_q};
        if (fill_rank_q == 4'd13) begin
          fill_rank_d = 4'd1;
          fill_suit_d = fill_suit_q + 2'd1;
          if (fill_suit_q == 2'd3) fill_deck_d = fill_deck_q + 3'd1;
        end else begin
          fill_rank_d = fill_rank_q + 4'd1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_SHUF_RD;
          lfsr_d  = seed_eff;
          cut_d   = 1'b0;
        end else begin
          idx_d = idx_q + ONE_IDX;
        end
      end
      ST_SHUF_RD: begin
        lfsr_d   = lfsr_nx;
        j_d      = j_new;
        swap_i_d = mem_q[idx_q];
        swap_j_d = mem_q[j_new];
        state_d  = ST_SHUF_SW;
      end
      ST_SHUF_SW: begin
        wr_a_en = 1'b1;
        wr_b_en = 1'b1;
        if (idx_q == ONE_IDX) begin
          state_d = ST_LOAD;
        end else begin
          idx_d   = idx_q - ONE_IDX;
          state_d = ST_SHUF_RD;
        end
      end
      ST_LOAD: begin
        idx_d   = '0;
        left_d  = N_CARDS;
        card_d  = mem_q[0];
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (hs) begin
          idx_d  = idx_q + ONE_IDX;
          left_d = left_after;
          if (left_q != 10'd1) card_d = mem_q[idx_q + ONE_IDX];
          if ((CUT_CARD != 0) && (left_after == CUT_LEFT)) cut_d = 1'b1;
        end
        if (start) begin
          state_d = ST_SHUF_RD;
          idx_d   = LAST_IDX;
          left_d  = 10'd0;
          lfsr_d  = seed_eff;
          cut_d   = 1'b0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      j_q         <= '0;
      left_q      <= 10'd0;
      lfsr_q      <= SEED_SUB;
      swap_i_q    <= '0;
      swap_j_q    <= '0;
      card_q      <= '0;
      cut_q       <= 1'b0;
      done_q      <= 1'b0;
      fill_rank_q <= 4'd1;
      fill_suit_q <= 2'd0;
      fill_deck_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      j_q         <= j_d;
      left_q      <= left_d;
      lfsr_q      <= lfsr_d;
      swap_i_q    <= swap_i_d;
      swap_j_q    <= swap_j_d;
      card_q      <= card_d;
      cut_q       <= cut_d;
      done_q      <= done_d;
      fill_rank_q <= fill_rank_d;
      fill_suit_q <= fill_suit_d;
      fill_deck_q <= fill_deck_d;
    end
  end

  // When i == j both ports target one entry with the same value, so order is moot.
  always_ff @(posedge clk) begin
    if (rst_n && wr_a_en) mem_q[wr_a_addr] <= wr_a_data;
    if (rst_n && wr_b_en) mem_q[wr_b_addr] <= wr_b_data;
  end

endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: directed sequence against two card_shoe instances (1 deck manual
// reshuffle, 2 decks with cut card and auto reshuffle) checked via expected-card queues.
module tb_card_shoe;

  logic        clk;
  logic [1:0]  rst_n, shuffle_req, card_ready;
  logic [15:0] seed [2];
  logic [1:0]  card_valid, busy, cut_reached, shuffle_done;
  logic [3:0]  card_rank [2];
  logic [1:0]  card_suit [2];
  logic [2:0]  card_deck [2];
  logic [9:0]  cards_left [2];
  logic [2:0]  state_dbg [2];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [8:0] exp_q_a [$];
  logic [8:0] exp_q_b [$];
  logic [8:0] mdl [2][416];
  int         left_m [2];
  int         seen [64];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  card_shoe #(.NUM_DECKS(1), .CUT_CARD(0), .AUTO_RESHUFFLE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .seed(seed[0]), .shuffle_req(shuffle_req[0]),
    .card_ready(card_ready[0]), .card_valid(card_valid[0]), .card_rank(card_rank[0]),
    .card_suit(card_suit[0]), .card_deck(card_deck[0]), .cards_left(cards_left[0]),
    .busy(busy[0]), .cut_reached(cut_reached[0]), .shuffle_done(shuffle_done[0]),
    .state_dbg(state_dbg[0])
  );

  card_shoe #(.NUM_DECKS(2), .CUT_CARD(78), .AUTO_RESHUFFLE(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .seed(seed[1]), .shuffle_req(shuffle_req[1]),
    .card_ready(card_ready[1]), .card_valid(card_valid[1]), .card_rank(card_rank[1]),
    .card_suit(card_suit[1]), .card_deck(card_deck[1]), .cards_left(cards_left[1]),
    .busy(busy[1]), .cut_reached(cut_reached[1]), .shuffle_done(shuffle_done[1]),
    .state_dbg(state_dbg[1])
  );

  // ---------------- reference model ----------------
  function automatic int ncards(input int d);
    return (d == 0) ? 52 : 104;
  endfunction

  function automatic int cut_at(input int d);
    return (d == 0) ? 0 : 78;
  endfunction

  function automatic void model_fill(input int d);
    for (int k = 0; k < ncards(d); k++)
      mdl[d][k] = {3'(k / 52), 2'((k / 13) % 4), 4'(k % 13 + 1)};
  endfunction

  function automatic void model_shuffle(input int d, input logic [15:0] s);
    logic [15:0] l;
    logic [31:0] p;
    logic [8:0]  t;
    int          j;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    for (int i = ncards(d) - 1; i >= 1; i--) begin
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      p = {16'h0000, l} * 32'(i + 1);
      j = int'(p[31:16]);
      t = mdl[d][i];
      mdl[d][i] = mdl[d][j];
      mdl[d][j] = t;
    end
  endfunction

  // ---------------- scoreboard ----------------
  function automatic void clear_exp(input int d);
    if (d == 0) exp_q_a.delete();
    else exp_q_b.delete();
  endfunction

  function automatic void push_model(input int d);
    for (int k = 0; k < ncards(d); k++) begin
      if (d == 0) exp_q_a.push_back(mdl[d][k]);
      else exp_q_b.push_back(mdl[d][k]);
    end
  endfunction

  function automatic logic [8:0] pop_exp(input int d);
    if (d == 0) return (exp_q_a.size() > 0) ? exp_q_a.pop_front() : 9'h1FF;
    return (exp_q_b.size() > 0) ? exp_q_b.pop_front() : 9'h1FF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void clear_seen();
    for (int i = 0; i < 64; i++) seen[i] = 0;
  endfunction

  task automatic chk_perm(input int mult);
    int ok = 0;
    for (int s = 0; s < 4; s++)
      for (int r = 1; r <= 13; r++)
        if (seen[s * 16 + r] == mult) ok++;
    chk("perm", ok, 52);
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_reset(input int d);
    chk("rst_valid", card_valid[d], 0);
    chk("rst_rank", card_rank[d], 0);
    chk("rst_suit", card_suit[d], 0);
    chk("rst_deck", card_deck[d], 0);
    chk("rst_left", cards_left[d], 0);
    chk("rst_busy", busy[d], 1);
    chk("rst_cut", cut_reached[d], 0);
    chk("rst_done", shuffle_done[d], 0);
  endtask

  // Called at a negedge; asserts reset for one edge, then waits for the first card.
  task automatic reset_and_wait(input int d, input logic [15:0] sv, input logic [15:0] mv);
    int t = 0;
    int busy_low = 0;
    rst_n[d] = 1'b0;
    seed[d] = sv;
    card_ready[d] = 1'b0;
    shuffle_req[d] = 1'b0;
    @(negedge clk);
    check_reset(d);
    rst_n[d] = 1'b1;
    model_fill(d);
    clear_exp(d);
    model_shuffle(d, mv);
    push_model(d);
    while (!card_valid[d] && t < 4 * ncards(d)) begin
      if (busy[d] !== 1'b1) busy_low++;
      @(negedge clk);
      t++;
    end
    chk("rst_latency", t, 3 * ncards(d) - 1);
    chk("rst_busy_hold", busy_low, 0);
    chk("rst_busy_end", busy[d], 0);
    chk("rst_load_left", cards_left[d], ncards(d));
    left_m[d] = ncards(d);
  endtask

  // Called at the negedge after the shuffle-start edge (t = 0).
  task automatic wait_valid(input int d, input int lat, input int req_at);
    int t = 0;
    int done_early = 0;
    while (!card_valid[d] && t < lat + 50) begin
      if (shuffle_done[d] === 1'b1) done_early++;
      shuffle_req[d] = (t == req_at);
      @(negedge clk);
      t++;
    end
    shuffle_req[d] = 1'b0;
    chk("shuf_latency", t, lat);
    chk("done_pulse", shuffle_done[d], 1);
    chk("done_early", done_early, 0);
    chk("shuf_left", cards_left[d], ncards(d));
    left_m[d] = ncards(d);
    @(negedge clk);
    chk("done_clear", shuffle_done[d], 0);
  endtask

  task automatic drain(input int d, input int count, input bit rnd);
    int         got = 0;
    int         guard = 0;
    bit         stalled = 0;
    bit         cut_exp;
    logic [8:0] cur, held;
    while (got < count && guard < 4 * count + 20) begin
      card_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cut_exp = (cut_at(d) != 0) && (ncards(d) - left_m[d] >= cut_at(d));
      cur = {card_deck[d], card_suit[d], card_rank[d]};
      chk("drain_valid", card_valid[d], 1);
      chk("drain_left", cards_left[d], left_m[d]);
      chk("drain_cut", cut_reached[d], cut_exp);
      if (stalled) chk("stall_hold", cur, held);
      if (card_ready[d]) begin
        chk("card", cur, pop_exp(d));
        seen[{card_suit[d], card_rank[d]}]++;
        got++;
        left_m[d]--;
        stalled = 0;
      end else begin
        held = cur;
        stalled = 1;
      end
      @(negedge clk);
      guard++;
    end
    card_ready[d] = 1'b0;
    chk("drain_count", got, count);
    if (!rnd) chk("drain_cycles", guard, count);
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] sb;

  initial begin
    rst_n = 2'b00;
    shuffle_req = 2'b00;
    card_ready = 2'b00;
    seed[0] = 16'h1234;
    seed[1] = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);

    // Single deck: reset timing, full permutation, seed-0 substitution, rerun.
    reset_and_wait(0, 16'h1234, 16'h1234);
    clear_seen();
    drain(0, 52, 1'b0);
    chk_perm(1);
    reset_and_wait(0, 16'h0000, 16'hACE1);
    drain(0, 52, 1'b0);
    reset_and_wait(0, 16'h1234, 16'h1234);
    clear_seen();
    drain(0, 52, 1'b1);
    chk_perm(1);

    // Empty shoe without auto reshuffle waits in IDLE.
    repeat (5) @(negedge clk);
    chk("idle_valid", card_valid[0], 0);
    chk("idle_busy", busy[0], 0);
    chk("idle_left", cards_left[0], 0);

    // Explicit request; a second request while busy must not start another shuffle.
    seed[0] = 16'h5A5A;
    shuffle_req[0] = 1'b1;
    @(negedge clk);
    shuffle_req[0] = 1'b0;
    chk("req_busy", busy[0], 1);
    chk("req_valid", card_valid[0], 0);
    clear_exp(0);
    model_shuffle(0, 16'h5A5A);
    push_model(0);
    wait_valid(0, 103, 10);
    drain(0, 10, 1'b1);

    // Request coinciding with a handshake: card consumed, shuffle starts next cycle.
    card_ready[0] = 1'b1;
    shuffle_req[0] = 1'b1;
    chk("sim_valid", card_valid[0], 1);
    chk("sim_card", {card_deck[0], card_suit[0], card_rank[0]}, pop_exp(0));
    @(negedge clk);
    card_ready[0] = 1'b0;
    shuffle_req[0] = 1'b0;
    chk("sim_busy", busy[0], 1);
    chk("sim_valid_low", card_valid[0], 0);
    chk("sim_left", cards_left[0], 0);
    clear_exp(0);
    model_shuffle(0, 16'h5A5A);
    push_model(0);
    wait_valid(0, 103, -1);
    clear_seen();
    drain(0, 52, 1'b1);
    chk_perm(1);

    // Two decks: cut card, auto reshuffle, reset mid-shuffle.
    sb = 16'($urandom_range(1, 65535));
    reset_and_wait(1, sb, sb);
    clear_seen();
    drain(1, 104, 1'b1);
    chk_perm(2);
    chk("auto_busy", busy[1], 1);
    chk("auto_valid", card_valid[1], 0);
    chk("auto_left", cards_left[1], 0);
    chk("auto_cut_clr", cut_reached[1], 0);
    model_shuffle(1, sb);
    push_model(1);
    wait_valid(1, 207, -1);
    drain(1, 104, 1'b0);
    repeat (40) @(negedge clk);
    chk("mid_busy", busy[1], 1);
    sb = 16'($urandom_range(1, 65535));
    reset_and_wait(1, sb, sb);
    drain(1, 104, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/card_shoe.md
# card_shoe

Parametrised multi-deck card source for the video-poker datapath, and the successor to the single-deck dealer. It holds `NUM_DECKS` × 52 cards in on-chip storage, fills them in order after reset and performs a seeded, deterministic, hardware Fisher-Yates shuffle driven by an LFSR. Cards are delivered over a valid/ready stream at one card per cycle. It adds a cut-card flag and an optional automatic reshuffle when the shoe is exhausted.

## Interface
- `NUM_DECKS`, 1: decks in the shoe, 1..8; total cards N = 52·NUM_DECKS.
- `CUT_CARD`, 0: dealt count at which `cut_reached` sets; 0 disables it.
- `AUTO_RESHUFFLE`, 1: when 1, an empty shoe starts a shuffle automatically; when 0, it waits for `shuffle_req`.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `seed` input 16: shuffle seed, sampled at every shuffle start.
- `shuffle_req` input 1: request a full reshuffle; acted on only in IDLE.
- `card_ready` input 1: consumer accepts the presented card.
- `card_valid` output 1: `card_rank`, `card_suit` and `card_deck` hold a card.
- `card_rank` output 4: 1..13 (ace = 1).
- `card_suit` output 2: 0..3.
- `card_deck` output 3: source deck, 0..NUM_DECKS-1.
- `cards_left` output 10: undealt cards remaining.
- `busy` output 1: high in the FILL, SHUF_RD, SHUF_SW and LOAD states.
- `cut_reached` output 1: sticky; cleared at shuffle start.
- `shuffle_done` output 1: one-cycle pulse on entry to IDLE after a shuffle.

## Operation
- **Card encoding at fill.** Index k maps to rank = k mod 13 + 1, suit = (k/13) mod 4, deck = k/52.
- **LFSR.** 16-bit Galois register.
  - next = (l >> 1) ^ (l[0] ? 16'hB400 : 0).
  - Loaded from `seed` at shuffle start; a `seed` of 0 loads 16'hACE1 instead.
- **State machine: FILL → SHUF_RD → SHUF_SW → LOAD → IDLE.**
  - **FILL:** N cycles, writing index k on cycle k.
  - **Shuffle loop:** for i = N-1 down to 1.
    - SHUF_RD advances the LFSR once.
    - It computes j = (l_new · (i+1)) >> 16, so 0 ≤ j ≤ i, and reads cards[i] and cards[j].
    - SHUF_SW writes both cards back swapped; i = j is a legal no-op swap.
    - The loop takes 2(N-1) cycles.
  - **LOAD:** 1 cycle.
    - Sets the read pointer to 0 and `cards_left` to N.
    - Primes the output register with cards[0].
  - **IDLE:**
    - `card_valid` = (`cards_left` ≠ 0).
    - On `card_valid` && `card_ready`: pointer +1, `cards_left` −1, and the next card is presented the following cycle. A one-card-per-cycle stream is sustained.
- **Shuffle start.** `shuffle_req`, or empty shoe with AUTO_RESHUFFLE=1, enters SHUF_RD from the current card order. There is no refill; the deck is reshuffled as it stands.
  - `cut_reached` clears and `card_valid` drops.
  - `cards_left` is forced to 0 until LOAD.
- **Cut card.** `cut_reached` sets on the cycle the dealt count (N − `cards_left`) becomes CUT_CARD.

## Timing
- **Reset values** (any cycle with `rst_n` low; the state machine goes to FILL with k = 0):
  - `card_valid` 0, `card_rank`/`card_suit`/`card_deck` 0, `cards_left` 0.
  - `busy` 1, `cut_reached` 0, `shuffle_done` 0.
- **Reset latency.** The first `card_valid` is exactly 3N−1 cycles after the first edge with `rst_n` high: 155 for N = 52.
- **Reshuffle latency.** From shuffle start to `card_valid` is 2(N−1)+1 cycles.
- **Output stability.** While `card_valid` && !`card_ready`, all card outputs and `cards_left` are held stable.
- **Simultaneous events.**
  - `shuffle_req` with a handshake in the same IDLE cycle: the handshake completes first, then the shuffle starts the next cycle.
  - The last card taken with AUTO_RESHUFFLE=1: the shuffle starts on the next cycle.
  - With AUTO_RESHUFFLE=0 the shoe stays in IDLE with `card_valid` low until `shuffle_req`.
- **Ignored inputs.** `shuffle_req` during `busy` is ignored and not queued. `card_ready` without `card_valid` has no effect.
- **Reset mid-shuffle or mid-deal.** Restarts FILL; the storage is rewritten in order.

## Test plan
- **Reset timing.** NUM_DECKS=1, seed=16'h1234; release reset → `busy`=1 for 154 cycles, `card_valid` rises at cycle 155, `cards_left`=52.
- **Permutation.** Drain 52 cards with `card_ready`=1 → all 52 (rank, suit) pairs appear exactly once, one per cycle. A rerun with the same seed gives an identical order; seed 0 gives the same order as seed 16'hACE1.
- **Backpressure.** Toggle `card_ready` pseudo-randomly → no card duplicated or dropped; outputs stay stable while stalled.
- **Cut card.** NUM_DECKS=2, CUT_CARD=78 → `cut_reached` rises on the 78th accepted card and clears at the next shuffle start. Drain all 104 cards → automatic shuffle, `shuffle_done` pulse, `card_valid` 207 cycles after the last handshake.
- **Shuffle request.** `shuffle_req` with a handshake in the same cycle → that card is consumed and the shuffle starts next cycle. A second `shuffle_req` while `busy` → no extra shuffle.
- **Reset mid-operation.** Assert `rst_n`=0 mid-shuffle → all outputs take reset values next edge; the full 3N−1 sequence restarts.
